// File: rtl/n2_iq_prefetch_ctrl_if.sv
// Instruction-memory fetch bus between the IQ prefetch controller (master) and imem (slave).
// Responses are in order; err is qualified by rvalid.
interface n2_iq_prefetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/n2_iq_prefetch_ctrl.sv
// Instruction prefetch sequencer: issues credit-limited imem requests and writes in-order
// responses into the pre-decoded instruction queue, dropping stale responses after a redirect.
module n2_iq_prefetch_ctrl #(
    parameter logic [31:0] PROGADDR_RESET  = 32'h0,
    parameter int          IQ_DEPTH        = 8,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            fetch_en_i,
    input  logic                            redirect_i,
    input  logic [31:0]                     redirect_pc_i,
    input  logic                            iq_pop_i,
    n2_iq_prefetch_ctrl_if.master           imem,
    output logic                            iq_wr_o,
    output logic [$clog2(IQ_DEPTH)-1:0]     iq_wr_ptr_o,
    output logic [31:0]                     iq_wdata_o,
    output logic [31:0]                     iq_wpc_o,
    output logic                            iq_flush_o,
    output logic [$clog2(IQ_DEPTH+1)-1:0]   iq_count_o,
    output logic                            fetch_err_o,
    output logic [31:0]                     fetch_err_pc_o
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int OUT_W = 2;

    typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d, disc_q, disc_d, live, push_idx;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W:0]     credit;
    logic [31:0]        addr_d;
    logic [31:0]        pc_fifo [MAX_OUTSTANDING];
    logic               gnt_fire, rsp_drop, rsp_live, err_event, push, req_d;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        gnt_fire  = imem.req & imem.gnt;
        rsp_drop  = imem.rvalid & (disc_q != '0);
        rsp_live  = imem.rvalid & (disc_q == '0);
        err_event = rsp_live & imem.err & ~redirect_i;
        iq_wr_o   = rsp_live & ~imem.err & ~redirect_i;
        iq_wdata_o = imem.rdata;
        iq_wpc_o   = pc_fifo[0];

        // The PC FIFO only holds addresses whose responses will be kept.
        live     = out_q - disc_q;
        push     = gnt_fire & ~redirect_i & ~err_event;
        push_idx = live - OUT_W'(rsp_live);

        out_d  = out_q + OUT_W'(gnt_fire) - OUT_W'(imem.rvalid);
        disc_d = (redirect_i | err_event) ? out_d : disc_q - OUT_W'(rsp_drop);

        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (err_event) state_d = ERR;
            ERR:     state_d = ERR;
            default: state_d = BOOT;
        endcase
        if (redirect_i) state_d = RUN;

        if (redirect_i) count_d = '0;
        else count_d = iq_count_o + CNT_W'(iq_wr_o) - CNT_W'(iq_pop_i && (iq_count_o != '0));

        if (redirect_i)    addr_d = {redirect_pc_i[31:2], 2'b00};
        else if (gnt_fire) addr_d = imem.addr + 32'd4;
        else               addr_d = imem.addr;

        // A raised request is held until granted; a redirect or a fault withdraws it.
        credit = {1'b0, count_d} + (CNT_W+1)'(out_d);
        req_d  = (imem.req & ~imem.gnt & ~redirect_i & ~err_event)
               | ((state_d == RUN) & fetch_en_i
                  & (credit < (CNT_W+1)'(IQ_DEPTH))
                  & (out_d < OUT_W'(MAX_OUTSTANDING)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= BOOT;
            imem.req       <= 1'b0;
            imem.addr      <= PROGADDR_RESET;
            out_q          <= '0;
            disc_q         <= '0;
            iq_count_o     <= '0;
            iq_wr_ptr_o    <= '0;
            iq_flush_o     <= 1'b0;
            fetch_err_o    <= 1'b0;
            fetch_err_pc_o <= '0;
        end else begin
            state_q     <= state_d;
            imem.req    <= req_d;
            imem.addr   <= addr_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            iq_count_o  <= count_d;
            iq_wr_ptr_o <= iq_wr_ptr_o + PTR_W'(iq_wr_o);
            iq_flush_o  <= redirect_i;
            if (redirect_i)     fetch_err_o <= 1'b0;
            else if (err_event) fetch_err_o <= 1'b1;
            if (err_event) fetch_err_pc_o <= pc_fifo[0];
        end
    end

    // NOTE: the PC FIFO is storage only; validity comes from the counters, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (push && (push_idx == OUT_W'(i)))
                pc_fifo[i] <= imem.addr;
            else if (rsp_live && (i < MAX_OUTSTANDING - 1))
                pc_fifo[i] <= pc_fifo[(i + 1) % MAX_OUTSTANDING];
        end
    end
endmodule

// File: tb/tb_n2_iq_prefetch_ctrl.sv
// Directed bench for n2_iq_prefetch_ctrl: an in-order imem model feeds a scoreboard of granted
// PCs that is popped and compared whenever a response reaches the IQ write port.
module tb_n2_iq_prefetch_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_en_i, redirect_i, iq_pop_i;
    logic [31:0] redirect_pc_i;
    logic        iq_wr_o, iq_flush_o, fetch_err_o;
    logic [2:0]  iq_wr_ptr_o;
    logic [3:0]  iq_count_o;
    logic [31:0] iq_wdata_o, iq_wpc_o, fetch_err_pc_o;

    n2_iq_prefetch_ctrl_if imem ();

    n2_iq_prefetch_ctrl #(
        .PROGADDR_RESET (32'h0),
        .IQ_DEPTH       (8),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .iq_pop_i      (iq_pop_i),
        .imem          (imem.master),
        .iq_wr_o       (iq_wr_o),
        .iq_wr_ptr_o   (iq_wr_ptr_o),
        .iq_wdata_o    (iq_wdata_o),
        .iq_wpc_o      (iq_wpc_o),
        .iq_flush_o    (iq_flush_o),
        .iq_count_o    (iq_count_o),
        .fetch_err_o   (fetch_err_o),
        .fetch_err_pc_o(fetch_err_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          gnt_en, rsp_en, err_en;
    logic [31:0] err_addr;
    logic [31:0] m_addr, m_err_pc, first_wpc, hold_addr;
    int          m_count, m_ptr, n_gnt, n_wr, g0, w0;
    bit          m_flush, m_err, m_in_err, first_arm;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the bus model, compare against the scoreboard, advance the model.
    task automatic cyc();
        rsp_t h;
        bit   gnt, rv, e, exp_wr, err_ev;
        gnt = gnt_en && imem.req;
        rv  = rsp_en && (rsp_q.size() > 0);
        if (rv) h = rsp_q[0];
        else    h = '{pc: 32'h0, stale: 1'b1};
        e = rv && err_en && (h.pc == err_addr);
        imem.gnt    = gnt;
        imem.rvalid = rv;
        imem.rdata  = rv ? data_of(h.pc) : 32'h0;
        imem.err    = e;
        #1;
        check("count", 32'(iq_count_o), 32'(m_count));
        check("wr_ptr", 32'(iq_wr_ptr_o), 32'(m_ptr));
        check("flush", 32'(iq_flush_o), 32'(m_flush));
        check("fetch_err", 32'(fetch_err_o), 32'(m_err));
        check("err_pc", fetch_err_pc_o, m_err_pc);
        if (imem.req) check("addr", imem.addr, m_addr);
        if (m_in_err) check("req_in_err", 32'(imem.req), 32'h0);
        exp_wr = rv && !h.stale && !e && !redirect_i;
        check("iq_wr", 32'(iq_wr_o), 32'(exp_wr));
        if (exp_wr) begin
            check("wdata", iq_wdata_o, data_of(h.pc));
            check("wpc", iq_wpc_o, h.pc);
        end
        if (iq_wr_o) begin
            n_wr++;
            if (first_arm) begin
                first_wpc = iq_wpc_o;
                first_arm = 1'b0;
            end
        end
        err_ev = rv && !h.stale && e && !redirect_i;
        if (rv) void'(rsp_q.pop_front());
        if (err_ev) begin
            m_err    = 1'b1;
            m_err_pc = h.pc;
            m_in_err = 1'b1;
            foreach (rsp_q[i]) rsp_q[i].stale = 1'b1;
        end
        if (gnt) begin
            rsp_q.push_back('{pc: m_addr, stale: (redirect_i || err_ev)});
            m_addr = m_addr + 32'd4;
            n_gnt++;
        end
        if (redirect_i) begin
            foreach (rsp_q[i]) rsp_q[i].stale = 1'b1;
            m_addr   = {redirect_pc_i[31:2], 2'b00};
            m_err    = 1'b0;
            m_in_err = 1'b0;
            m_count  = 0;
        end else begin
            m_count = m_count + int'(exp_wr) - int'(iq_pop_i && (m_count != 0));
        end
        m_ptr   = (m_ptr + int'(exp_wr)) % 8;
        m_flush = redirect_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; iq_pop_i = 1'b0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0; imem.err = 1'b0;
        gnt_en = 1'b0; rsp_en = 1'b0; err_en = 1'b0; err_addr = 32'h0;
        m_addr = 32'h0; m_err_pc = 32'h0; m_count = 0; m_ptr = 0; m_flush = 1'b0;
        m_err = 1'b0; m_in_err = 1'b0; n_gnt = 0; n_wr = 0; first_arm = 1'b0; first_wpc = 32'h0;

        // Reset values while resetn is held low.
        #12;
        check("rst_req", 32'(imem.req), 32'h0);
        check("rst_addr", imem.addr, 32'h0);
        check("rst_iq_wr", 32'(iq_wr_o), 32'h0);
        check("rst_wr_ptr", 32'(iq_wr_ptr_o), 32'h0);
        check("rst_flush", 32'(iq_flush_o), 32'h0);
        check("rst_count", 32'(iq_count_o), 32'h0);
        check("rst_fetch_err", 32'(fetch_err_o), 32'h0);
        check("rst_err_pc", fetch_err_pc_o, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fill the IQ from reset: eight fetches 0x00..0x1C, then credit runs out.
        fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (14) cyc();
        check("fill_grants", 32'(n_gnt), 32'd8);
        check("fill_count", 32'(iq_count_o), 32'd8);
        check("fill_req_low", 32'(imem.req), 32'h0);
        check("fill_ptr_wrap", 32'(iq_wr_ptr_o), 32'h0);

        // Continuous pops: steady one write per cycle.
        iq_pop_i = 1'b1;
        repeat (12) cyc();
        n_wr = 0;
        repeat (8) cyc();
        check("steady_writes", 32'(n_wr), 32'd8);

        // Drain to empty (pops at count 0 ignored), then build two outstanding requests.
        fetch_en_i = 1'b0;
        repeat (12) cyc();
        check("drained_count", 32'(iq_count_o), 32'h0);
        iq_pop_i = 1'b0; rsp_en = 1'b0; fetch_en_i = 1'b1;
        repeat (4) cyc();
        check("two_outstanding", 32'(rsp_q.size()), 32'd2);
        redirect_i = 1'b1; redirect_pc_i = 32'h1002;
        cyc();
        redirect_i = 1'b0;
        check("redir_addr", imem.addr, 32'h1000);
        check("redir_flush", 32'(iq_flush_o), 32'h1);
        first_arm = 1'b1; rsp_en = 1'b1;
        repeat (8) cyc();
        check("redir_first_pc", first_wpc, 32'h1000);

        // Redirect in the same cycle as a grant.
        iq_pop_i = 1'b1;
        for (int i = 0; i < 10 && !imem.req; i++) cyc();
        check("req_before_redirect", 32'(imem.req), 32'h1);
        g0 = n_gnt;
        rsp_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h2000;
        cyc();
        redirect_i = 1'b0; rsp_en = 1'b1;
        check("gnt_at_redirect", 32'(n_gnt), 32'(g0 + 1));
        repeat (6) cyc();

        // Redirect in the same cycle as a live response.
        rsp_en = 1'b0;
        repeat (3) cyc();
        check("fresh_pending", 32'((rsp_q.size() > 0) && !rsp_q[0].stale), 32'h1);
        gnt_en = 1'b0; rsp_en = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h3000;
        w0 = n_wr;
        cyc();
        redirect_i = 1'b0; gnt_en = 1'b1;
        check("no_wr_at_redirect", 32'(n_wr), 32'(w0));
        repeat (8) cyc();

        // Error response at 0x20, then recovery by redirect to 0x40.
        err_en = 1'b1; err_addr = 32'h20; redirect_i = 1'b1; redirect_pc_i = 32'h10;
        cyc();
        redirect_i = 1'b0;
        repeat (12) cyc();
        check("err_flag", 32'(fetch_err_o), 32'h1);
        check("err_pc_0x20", fetch_err_pc_o, 32'h20);
        g0 = n_gnt;
        repeat (3) cyc();
        check("err_no_grants", 32'(n_gnt), 32'(g0));
        err_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        cyc();
        redirect_i = 1'b0;
        check("err_cleared", 32'(fetch_err_o), 32'h0);
        first_arm = 1'b1;
        repeat (8) cyc();
        check("resume_pc_0x40", first_wpc, 32'h40);

        // Grant withheld for five cycles: request and address must hold.
        gnt_en = 1'b0;
        for (int i = 0; i < 10 && !imem.req; i++) cyc();
        check("stall_req_up", 32'(imem.req), 32'h1);
        hold_addr = imem.addr;
        repeat (5) begin
            cyc();
            check("stall_req", 32'(imem.req), 32'h1);
            check("stall_addr", imem.addr, hold_addr);
        end
        gnt_en = 1'b1;

        // fetch_en dropped with responses still in flight.
        rsp_en = 1'b0;
        repeat (2) cyc();
        fetch_en_i = 1'b0; rsp_en = 1'b1;
        w0 = n_wr;
        repeat (6) cyc();
        check("fetch_off_req", 32'(imem.req), 32'h0);
        check("fetch_off_drained", 32'(rsp_q.size()), 32'h0);
        check("fetch_off_landed", 32'(n_wr > w0), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/n2_iq_prefetch_ctrl.md
Name: n2_iq_prefetch_ctrl

Overview:
- Sequences instruction prefetch from the instruction memory port into the 8-entry pre-decoded instruction queue (IQ) that feeds decode.
- Owns the fetch PC, the IQ write pointer and the IQ occupancy/credit accounting.
- On a redirect it restarts fetch and discards stale in-flight responses, so decode only ever sees instructions on the new path.
- Sits between the imem bus and the IQ write side of the decode stage.

Parameters:
- PROGADDR_RESET, 32'h0: first fetch address after reset.
- IQ_DEPTH, 8: IQ entries; power of two; pointer width is log2(IQ_DEPTH).
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered imem requests, range 1..3.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_en_i  in  1  enables new requests; in-flight ones still complete
- redirect_i  in  1  branch/trap redirect strobe
- redirect_pc_i  in  32  new fetch PC, bits[1:0] ignored
- iq_pop_i  in  1  decode consumed one IQ entry this cycle
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word-aligned fetch address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  in-order response valid
- imem_rdata_i  in  32  response data
- imem_err_i  in  1  bus error, qualified by rvalid
- iq_wr_o  out  1  write IQ entry at iq_wr_ptr_o
- iq_wr_ptr_o  out  3  IQ write pointer
- iq_wdata_o  out  32  opcode to write
- iq_wpc_o  out  32  PC of the written opcode
- iq_flush_o  out  1  one-cycle pulse; decode sets its rd ptr to iq_wr_ptr_o
- iq_count_o  out  4  valid IQ entries, 0..8
- fetch_err_o  out  1  sticky fetch fault flag
- fetch_err_pc_o  out  32  PC of the faulting fetch

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk.
- Reset values: imem_req_o=0, imem_addr_o=PROGADDR_RESET, iq_wr_o=0, iq_wr_ptr_o=0, iq_flush_o=0, iq_count_o=0, fetch_err_o=0, fetch_err_pc_o=0. Internal outstanding and discard counters reset to 0; state=BOOT.
- FSM states:
  - BOOT: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - ERR: entered on an accepted error response; no requests issued; exits to RUN only on redirect_i.
- Credit rule: imem_req_o=1 in RUN when fetch_en_i && (iq_count + outstanding) < IQ_DEPTH && outstanding < MAX_OUTSTANDING.
  - Once raised, req and addr hold stable until gnt, unless a redirect arrives.
  - On gnt: outstanding++ and imem_addr_o += 4, with 32-bit wrap.
  - Back-to-back grants are allowed, at one per cycle.
- Response rule: rvalid decrements outstanding.
  - If the discard counter is >0, the response is dropped and discard is decremented.
  - Otherwise iq_wr_o=1 in the same cycle, with iq_wdata_o=rdata and iq_wpc_o=the PC FIFO head. The PC FIFO is internal, holds the granted addresses, and has MAX_OUTSTANDING entries.
  - iq_wr_ptr_o increments the cycle after a write, wrapping 7→0.
  - Write latency is combinational from rvalid, so there is 0 extra cycles of response-to-IQ delay.
- Count: iq_count_o next = count + write − iq_pop_i, so simultaneous write and pop leave it unchanged.
  - A pop at count 0 is ignored.
  - Count never exceeds IQ_DEPTH, which the credit rule guarantees.
- Redirect at cycle N:
  - imem_addr_o = {redirect_pc_i[31:2],2'b00} from N+1.
  - iq_count → 0 and iq_flush_o=1 at N+1.
  - discard = outstanding after cycle N's events: including a gnt at N, excluding an rvalid at N. A non-discarded rvalid at N is not written.
  - A pending ungranted request is withdrawn. New requests may issue from N+1 in parallel with discarding; in-order responses guarantee correctness.
  - The PC FIFO is cleared of stale entries, which are dropped with the discards.
  - iq_wr_ptr_o is unchanged.
- Error: a non-discarded rvalid with imem_err_i=1:
  - no IQ write;
  - fetch_err_o=1 and fetch_err_pc_o=its PC;
  - state ERR, with remaining outstanding responses discarded.
  - redirect_i clears fetch_err_o.
- fetch_en_i=0 only blocks new requests; a request already raised completes its handshake.
- Reset mid-operation clears everything asynchronously. Responses to pre-reset requests are outside the contract; the bus is reset together with this block.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, no pops → addresses 0,4,...,0x1C issued; 8 IQ writes with ptr 0..7; iq_count_o=8; req drops; wr_ptr wraps to 0.
- Continuous pops with 1-cycle response latency and MAX_OUTSTANDING=2 → steady one write/cycle; count stable; iq_wpc_o matches its opcode.
- Two requests outstanding, redirect to 0x1002 → next addr 0x1000; both old responses dropped (no iq_wr); iq_flush_o pulses; the first write carries pc 0x1000.
- Redirect in the same cycle as a gnt, and separately the same cycle as an rvalid → the granted request is discarded later; the same-cycle response is not written.
- Error response at pc 0x20 → fetch_err_o=1, fetch_err_pc_o=0x20, no further req; redirect to 0x40 clears the flag and fetch resumes at 0x40.
- gnt held low for 5 cycles → req/addr stable throughout; fetch_en_i=0 mid-stream stops new requests while outstanding responses still land.
